bound_flash_sequencer: RTL and testbench

- Single-clock sequencer for the 16-LED bound-flasher display.
- Replaces the divided-clock approach with a clock-enable prescaler.
- Owns the phase FSM and lit-level counter, with flick kickback, and drives `led_state` through a thermometer decoder.
- Sits between the board-level flick input and the LED pins; all logic runs on `clk`.

---
 rtl/bound_flasher_pkg.sv | 23 ++
 rtl/thermo_decoder.sv | 16 +
 rtl/bound_flash_sequencer.sv | 128 ++++++++++++
 tb/tb_bound_flash_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bound_flasher_pkg.sv
// bound_flasher_pkg: shared phase encoding and default level constants for the bound flasher.
//   phase_e    : IDLE..DN3 encoded 0..6 on 3 bits
//   *_D        : default LED count, level width, turnaround and kickback levels
package bound_flasher_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP1  = 3'd1,
        DN1  = 3'd2,
        UP2  = 3'd3,
        DN2  = 3'd4,
        UP3  = 3'd5,
        DN3  = 3'd6
    } phase_e;

    localparam int NUM_LED_D  = 16;
    localparam int LVL_W_D    = 5;
    localparam int MID_LVL_D  = 5;
    localparam int TOP2_LVL_D = 11;
    localparam int KB_LO_D    = 5;
    localparam int KB_HI_D    = 10;

endpackage

// File: rtl/thermo_decoder.sv
// thermo_decoder: combinational level to thermometer mask, saturating at all-ones.
//   level : IN_W-bit lit count
//   mask  : OUT_W-bit pattern, bit i set when level > i
module thermo_decoder #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  level,
    output logic [OUT_W-1:0] mask
);

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign mask[i] = 32'(level) > i;
    end

endmodule

// File: rtl/bound_flash_sequencer.sv
// bound_flash_sequencer: clock-enabled phase FSM and lit-level counter with flick kickback.
//   clk, rst  : system clock, synchronous active-high reset
//   flick     : start / kickback request, level-sampled
//   led_state : thermometer LED pattern decoded from level
//   level     : current lit count
//   phase     : current FSM state encoding
//   busy      : high while phase != IDLE
//   done      : one-clock pulse when the sequence completes
module bound_flash_sequencer
    import bound_flasher_pkg::*;
#(
    parameter int NUM_LED  = NUM_LED_D,
    parameter int LVL_W    = LVL_W_D,
    parameter int TICK_DIV = 2,
    parameter int MID_LVL  = MID_LVL_D,
    parameter int TOP2_LVL = TOP2_LVL_D,
    parameter int KB_LO    = KB_LO_D,
    parameter int KB_HI    = KB_HI_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flick,
    output logic [NUM_LED-1:0] led_state,
    output logic [LVL_W-1:0]   level,
    output logic [2:0]         phase,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [LVL_W-1:0] L_TOP  = LVL_W'(NUM_LED);
    localparam logic [LVL_W-1:0] L_MID  = LVL_W'(MID_LVL);
    localparam logic [LVL_W-1:0] L_TOP2 = LVL_W'(TOP2_LVL);
    localparam logic [LVL_W-1:0] L_KLO  = LVL_W'(KB_LO);
    localparam logic [LVL_W-1:0] L_KHI  = LVL_W'(KB_HI);

    phase_e           state;
    logic [CNT_W-1:0] cnt;
    logic             tick, up, dn, bad;
    logic [LVL_W-1:0] inc, dec;

    assign tick  = cnt == CNT_W'(TICK_DIV - 1);
    assign inc   = level + 1'b1;
    assign dec   = level - 1'b1;
    assign up    = state == UP1 || state == UP2 || state == UP3;
    assign dn    = state == DN1 || state == DN2 || state == DN3;
    // Combinations the FSM can never reach on its own; recover to a clean IDLE.
    assign bad   = level > L_TOP || state > DN3 || (up && level == L_TOP) ||
                   (dn && level == '0) || (state == IDLE && level != '0);
    assign phase = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            level <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= tick ? '0 : cnt + 1'b1;
            if (bad) begin
                state <= IDLE;
                level <= '0;
                busy  <= 1'b0;
            end else if (state == IDLE) begin
                // Restart the prescaler so the first step lands TICK_DIV clocks later.
                if (flick) begin
                    state <= UP1;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            end else if (tick) begin
                case (state)
                    UP1: begin
                        level <= inc;
                        if (inc == L_TOP) state <= DN1;
                    end
                    DN1: begin
                        level <= dec;
                        if (dec == L_MID) state <= UP2;
                    end
                    UP2: begin
                        if (flick && level == L_KHI) begin
                            level <= dec;
                            state <= DN1;
                        end else begin
                            level <= inc;
                            if (inc == L_TOP2) state <= DN2;
                        end
                    end
                    DN2: begin
                        level <= dec;
                        if (dec == '0) state <= UP3;
                    end
                    UP3: begin
                        if (flick && (level == L_KLO || level == L_KHI)) begin
                            level <= dec;
                            state <= DN2;
                        end else begin
                            level <= inc;
                            if (inc == L_TOP) state <= DN3;
                        end
                    end
                    DN3: begin
                        level <= dec;
                        if (dec == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        level <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    thermo_decoder #(.IN_W(LVL_W), .OUT_W(NUM_LED)) u_thermo (
        .level (level),
        .mask  (led_state)
    );

endmodule

// File: tb/tb_bound_flash_sequencer.sv
// tb_bound_flash_sequencer: directed checks of two sequencers (step every clock and every 4th clock).
module tb_bound_flash_sequencer;

    localparam int P_IDLE = 0, P_UP1 = 1, P_DN1 = 2, P_UP2 = 3, P_DN2 = 4, P_UP3 = 5, P_DN3 = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f1 = 1'b0, f4 = 1'b0;
    logic [15:0] led1, led4;
    logic [4:0]  lvl1, lvl4;
    logic [2:0]  ph1, ph4;
    logic        busy1, busy4, done1, done4;

    int errors = 0;
    int checks = 0;
    int exp_lvl[$];
    int exp_ph[$];
    int nom[$];

    always #5 clk = ~clk;

    bound_flash_sequencer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .flick(f1), .led_state(led1),
        .level(lvl1), .phase(ph1), .busy(busy1), .done(done1)
    );

    bound_flash_sequencer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .flick(f4), .led_state(led4),
        .level(lvl4), .phase(ph4), .busy(busy4), .done(done4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s idx=%0d got=%0h exp=%0h", tag, idx, got, exp);
        end
    endtask

    task automatic add_seg(input int ph, input int from, input int to, input int end_ph);
        int s = (to >= from) ? 1 : -1;
        for (int v = from; v != to + s; v += s) begin
            exp_lvl.push_back(v);
            exp_ph.push_back(v == to ? end_ph : ph);
        end
    endtask

    // Expected level/phase after each tick; mode 2 kicks back in UP2 at 10, mode 3 in UP3 at 5.
    task automatic build(input int mode);
        exp_lvl.delete();
        exp_ph.delete();
        add_seg(P_UP1, 1, 16, P_DN1);
        add_seg(P_DN1, 15, 5, P_UP2);
        if (mode == 2) begin
            add_seg(P_UP2, 6, 10, P_UP2);
            add_seg(P_DN1, 9, 5, P_UP2);
        end
        add_seg(P_UP2, 6, 11, P_DN2);
        add_seg(P_DN2, 10, 0, P_UP3);
        if (mode == 3) begin
            add_seg(P_UP3, 1, 5, P_UP3);
            add_seg(P_DN2, 4, 0, P_UP3);
        end
        add_seg(P_UP3, 1, 16, P_DN3);
        add_seg(P_DN3, 15, 0, P_IDLE);
    endtask

    task automatic run1(input int mode);
        int p_l = 0, p_p = P_UP1;
        bit kicked = 0;
        build(mode);
        f1 = 1'b1;
        step();
        f1 = 1'b0;
        chk("start_phase", mode, 32'(ph1), P_UP1);
        chk("start_level", mode, 32'(lvl1), 0);
        chk("start_busy", mode, 32'(busy1), 1);
        for (int k = 0; k < exp_lvl.size(); k++) begin
            case (mode)
                1: f1 = (p_p == P_DN1) || (p_p == P_UP1 && p_l == 5) || (p_p == P_UP2 && p_l == 9);
                2: f1 = !kicked && p_p == P_UP2 && p_l == 10;
                3: f1 = !kicked && p_p == P_UP3 && p_l == 5;
                default: f1 = 1'b0;
            endcase
            if (f1 && mode >= 2) kicked = 1;
            step();
            chk("level", k, 32'(lvl1), exp_lvl[k]);
            chk("led", k, 32'(led1), (32'h1 << exp_lvl[k]) - 1);
            chk("phase", k, 32'(ph1), exp_ph[k]);
            chk("done", k, 32'(done1), (k == exp_lvl.size() - 1) ? 1 : 0);
            p_l = exp_lvl[k];
            p_p = exp_ph[k];
        end
        f1 = 1'b0;
        chk("end_busy", mode, 32'(busy1), 0);
        chk("run_ticks", mode, 32'(exp_lvl.size()), (mode == 0 || mode == 1) ? 76 : 86);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_level", 0, 32'(lvl1), 0);
        chk("rst_led", 0, 32'(led1), 0);
        chk("rst_phase", 0, 32'(ph1), P_IDLE);
        chk("rst_busy", 0, 32'(busy1), 0);
        chk("rst_done", 0, 32'(done1), 0);
        step();
        chk("idle_stay", 0, 32'(ph1), P_IDLE);

        build(0);
        nom = exp_lvl;
        run1(0);
        step();
        chk("done_once", 0, 32'(done1), 0);
        chk("idle_after", 0, 32'(ph1), P_IDLE);

        run1(1);
        run1(2);
        run1(3);

        // flick held across the done clock restarts on the next clk
        f1 = 1'b1;
        step();
        chk("restart_phase", 0, 32'(ph1), P_UP1);
        chk("restart_busy", 0, 32'(busy1), 1);
        f1 = 1'b0;
        repeat (7) step();
        chk("mid_level", 7, 32'(lvl1), 7);
        chk("mid_led", 7, 32'(led1), 32'h7F);
        rst = 1'b1;
        step();
        chk("abort_level", 1, 32'(lvl1), 0);
        chk("abort_led", 1, 32'(led1), 0);
        chk("abort_phase", 1, 32'(ph1), P_IDLE);
        chk("abort_busy", 1, 32'(busy1), 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_phase", 3, 32'(ph1), P_IDLE);
        chk("post_rst_level", 3, 32'(lvl1), 0);

        f4 = 1'b1;
        step();
        f4 = 1'b0;
        chk("div_start_phase", 0, 32'(ph4), P_UP1);
        for (int c = 1; c <= 304; c++) begin
            step();
            chk("div_level", c, 32'(lvl4), (c < 4) ? 0 : nom[c / 4 - 1]);
            chk("div_done", c, 32'(done4), (c == 304) ? 1 : 0);
        end
        chk("div_busy", 0, 32'(busy4), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
